sipo_collector_32bit: RTL and testbench

Serial-in/parallel-out collector that sits directly downstream of the 32-bit SISO shift-register stage. It takes that stage's serial output bit stream, qualified by si_valid, and assembles it into WIDTH-bit words. It presents each completed word on a one-entry output buffer with a valid/ready handshake. A sync input aligns word boundaries, and a sticky flag records words dropped because of backpressure.

---
 rtl/sipo_collector_32bit.sv | 49 ++++
 tb/tb_sipo_collector_32bit.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/sipo_collector_32bit.sv
// sipo_collector_32bit: assembles a qualified serial bit stream into words behind a one-entry valid/ready buffer.
module sipo_collector_32bit #(
  parameter int WIDTH = 32,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                     clk,
  input  logic                     clear,
  input  logic                     si,
  input  logic                     si_valid,
  input  logic                     sync,
  output logic [WIDTH-1:0]         dout,
  output logic                     dout_valid,
  input  logic                     dout_ready,
  output logic [$clog2(WIDTH):0]   bit_cnt,
  output logic                     overflow
);
  localparam int CW = $clog2(WIDTH) + 1;
  typedef enum logic {EMPTY, FULL} state_t;
  state_t state, nstate;
  logic [WIDTH-1:0] shreg, shifted, sync_word, nshreg;
  logic [CW-1:0] ncnt;
  logic done, load, drop;
  always_comb begin
    shifted   = MSB_FIRST ? {shreg[WIDTH-2:0], si} : {si, shreg[WIDTH-1:1]};
    sync_word = MSB_FIRST ? {{(WIDTH-1){1'b0}}, si} : {si, {(WIDTH-1){1'b0}}};
    done      = si_valid & ~sync & (bit_cnt == CW'(WIDTH - 1));
    load      = done & ((state == EMPTY) | dout_ready);
    drop      = done & (state == FULL) & ~dout_ready;
    nshreg    = sync ? (si_valid ? sync_word : '0) : si_valid ? shifted : shreg;
    ncnt      = sync ? (si_valid ? CW'(1) : '0) : done ? '0 : si_valid ? bit_cnt + 1'b1 : bit_cnt;
    nstate    = load ? FULL : (state == FULL && dout_ready) ? EMPTY : state;
  end
  always_ff @(posedge clk) begin
    if (clear) begin
      state    <= EMPTY;
      shreg    <= '0;
      bit_cnt  <= '0;
      dout     <= '0;
      overflow <= 1'b0;
    end else begin
      state    <= nstate;
      shreg    <= nshreg;
      bit_cnt  <= ncnt;
      if (load) dout <= shifted;
      if (drop) overflow <= 1'b1;
    end
  end
  assign dout_valid = (state == FULL);
endmodule

// File: tb/tb_sipo_collector_32bit.sv
// tb_sipo_collector_32bit: directed checks of an MSB-first and an LSB-first collector sharing one stimulus stream.
module tb_sipo_collector_32bit;
  logic clk = 1'b0, clear = 1'b0, si = 1'b0, si_valid = 1'b0, sync = 1'b0, dout_ready = 1'b0;
  logic [31:0] m_dout, l_dout;
  logic m_valid, l_valid, m_ovf, l_ovf;
  logic [5:0] m_cnt, l_cnt;
  int total = 0, bad = 0;
  logic [31:0] w;
  sipo_collector_32bit #(.WIDTH(32), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .clear(clear), .si(si), .si_valid(si_valid), .sync(sync),
    .dout(m_dout), .dout_valid(m_valid), .dout_ready(dout_ready), .bit_cnt(m_cnt), .overflow(m_ovf));
  sipo_collector_32bit #(.WIDTH(32), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .clear(clear), .si(si), .si_valid(si_valid), .sync(sync),
    .dout(l_dout), .dout_valid(l_valid), .dout_ready(dout_ready), .bit_cnt(l_cnt), .overflow(l_ovf));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic step(input logic b, input logic v, input logic s);
    si = b; si_valid = v; sync = s;
    @(posedge clk); #1;
  endtask
  task automatic send_msb(input logic [31:0] d, input int n);
    for (int i = 0; i < n; i++) step(d[31-i], 1'b1, 1'b0);
  endtask
  task automatic do_clear();
    clear = 1'b1; si_valid = 1'b0; sync = 1'b0;
    @(posedge clk); #1;
    clear = 1'b0;
  endtask
  initial begin
    do_clear();
    chk("rst_dout", m_dout, 0);
    chk("rst_valid", m_valid, 0);
    chk("rst_cnt", m_cnt, 0);
    chk("rst_ovf", m_ovf, 0);
    // basic word, consumer always ready
    dout_ready = 1'b1;
    send_msb(32'hA5A50F0F, 31);
    chk("s1_cnt31", m_cnt, 31);
    chk("s1_notyet", m_valid, 0);
    step(1'b1, 1'b1, 1'b0);
    chk("s1_dout", m_dout, 32'hA5A50F0F);
    chk("s1_valid", m_valid, 1);
    chk("s1_cnt0", m_cnt, 0);
    chk("s1_ovf", m_ovf, 0);
    step(1'b0, 1'b0, 1'b0);
    chk("s1_onecycle", m_valid, 0);
    chk("s1_hold", m_dout, 32'hA5A50F0F);
    // backpressure drops the second word
    dout_ready = 1'b0;
    send_msb(32'h12345678, 32);
    chk("s2_w1", m_dout, 32'h12345678);
    chk("s2_v1", m_valid, 1);
    send_msb(32'hDEADBEEF, 32);
    chk("s2_stable", m_dout, 32'h12345678);
    chk("s2_v2", m_valid, 1);
    chk("s2_ovf", m_ovf, 1);
    dout_ready = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    chk("s2_drain", m_valid, 0);
    chk("s2_sticky", m_ovf, 1);
    chk("s2_keep", m_dout, 32'h12345678);
    // handshake coinciding with completion of the next word
    do_clear();
    dout_ready = 1'b0;
    send_msb(32'hCAFEF00D, 32);
    chk("s3_w1", m_dout, 32'hCAFEF00D);
    w = 32'h0BADC0DE;
    for (int i = 0; i < 31; i++) begin
      step(w[31-i], 1'b1, 1'b0);
      chk("s3_cont", m_valid, 1);
    end
    dout_ready = 1'b1;
    step(w[0], 1'b1, 1'b0);
    chk("s3_w2", m_dout, 32'h0BADC0DE);
    chk("s3_valid", m_valid, 1);
    chk("s3_noovf", m_ovf, 0);
    step(1'b0, 1'b0, 1'b0);
    chk("s3_drain", m_valid, 0);
    // gapped stream: bit_cnt holds when si_valid is low
    w = 32'h0000FFFF;
    for (int i = 0; i < 32; i++) begin
      step(w[31-i], 1'b1, 1'b0);
      if (i == 31) begin
        chk("s4_dout", m_dout, 32'h0000FFFF);
        chk("s4_valid", m_valid, 1);
      end
      step(1'b1, 1'b0, 1'b0);
      chk("s4_gapcnt", m_cnt, (i + 1) % 32);
    end
    chk("s4_after", m_dout, 32'h0000FFFF);
    chk("s4_consumed", m_valid, 0);
    // sync realigns after garbage
    for (int i = 0; i < 10; i++) step(i[0], 1'b1, 1'b0);
    chk("s5_garbage", m_cnt, 10);
    step(1'b1, 1'b1, 1'b1);
    chk("s5_synccnt", m_cnt, 1);
    chk("s5_novalid", m_valid, 0);
    w = 32'hC0000001;
    for (int i = 1; i < 32; i++) step(w[31-i], 1'b1, 1'b0);
    chk("s5_dout", m_dout, 32'hC0000001);
    chk("s5_valid", m_valid, 1);
    step(1'b0, 1'b0, 1'b1);
    chk("s5_syncidle", m_cnt, 0);
    chk("s5_bufuntouched", m_dout, 32'hC0000001);
    // clear mid-word with a full buffer and overflow set
    dout_ready = 1'b0;
    send_msb(32'hAAAA5555, 32);
    send_msb(32'h5555AAAA, 32);
    chk("s6_ovf", m_ovf, 1);
    chk("s6_kept", m_dout, 32'hAAAA5555);
    send_msb(32'hFFFFFFFF, 17);
    chk("s6_cnt17", m_cnt, 17);
    do_clear();
    chk("s6_dout0", m_dout, 0);
    chk("s6_valid0", m_valid, 0);
    chk("s6_cnt0", m_cnt, 0);
    chk("s6_ovf0", m_ovf, 0);
    dout_ready = 1'b1;
    send_msb(32'h3C3C5A5A, 32);
    chk("s6_word", m_dout, 32'h3C3C5A5A);
    chk("s6_wvalid", m_valid, 1);
    chk("s6_wovf", m_ovf, 0);
    // LSB-first instance
    do_clear();
    w = 32'hA5A50F0F;
    for (int i = 0; i < 32; i++) step(w[i], 1'b1, 1'b0);
    chk("s7_dout", l_dout, 32'hA5A50F0F);
    chk("s7_valid", l_valid, 1);
    chk("s7_cnt", l_cnt, 0);
    chk("s7_ovf", l_ovf, 0);
    step(1'b1, 1'b1, 1'b1);
    w = 32'h80000003;
    for (int i = 1; i < 32; i++) step(w[i], 1'b1, 1'b0);
    chk("s7_sync", l_dout, 32'h80000003);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
